ternary_lookup_engine: RTL

Parametrised ternary-match lookup stage for the RMT pipeline. It sits between the key extractor and the action engine of each stage. It holds `ENTRIES` key/mask/valid rows and `ENTRIES+1` action rows; the extra row is the default action used on a miss. Lookups run as a fully pipelined 3-cycle datapath. Key, mask and action rows are written in-band through the stage's AXI-Stream control path. It extends the fixed single-table engine with:
- configurable depth;
- lowest-index priority;
- a programmable miss action;
- entry invalidation;
- hit/miss counters.

---
 rtl/ternary_lookup_engine_if.sv | 15 +
 rtl/ternary_lookup_engine.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ternary_lookup_engine_if.sv
// AXI-Stream control bus used on both the ingress and forward sides of the lookup stage.
// There is no tready: the receiving block always accepts.
interface ternary_lookup_engine_if #(
  parameter int DATA_W = 256,
  parameter int USER_W = 128
);
  logic [DATA_W-1:0]   tdata;
  logic [USER_W-1:0]   tuser;
  logic [DATA_W/8-1:0] tkeep;
  logic                tvalid;
  logic                tlast;

  modport master (output tdata, tuser, tkeep, tvalid, tlast);
  modport slave  (input  tdata, tuser, tkeep, tvalid, tlast);
endinterface

// File: rtl/ternary_lookup_engine.sv
// Ternary-match lookup stage with a 3-cycle lookup pipeline. Rows are written in-band over
// the AXI-Stream control path; packets for other stages are forwarded after one register.
module ternary_lookup_engine #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int STAGE_ID             = 0,
  parameter int PHV_LEN              = 1124,
  parameter int KEY_LEN              = 197,
  parameter int ACT_LEN              = 625,
  parameter int ENTRIES              = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [KEY_LEN-1:0]    extract_key,
  input  logic [KEY_LEN-1:0]    extract_mask,
  input  logic                  key_valid,
  input  logic [PHV_LEN-1:0]    phv_in,
  output logic [ACT_LEN-1:0]    action,
  output logic                  action_valid,
  output logic [PHV_LEN-1:0]    phv_out,
  output logic                  hit,
  output logic [7:0]            hit_index,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt,
  ternary_lookup_engine_if.slave  c_s_axis,
  ternary_lookup_engine_if.master c_m_axis
);
  localparam int W = C_S_AXIS_DATA_WIDTH;
  localparam int NBEATS = (ACT_LEN + W - 1) / W;
  localparam int ABUF_W = NBEATS * W;
  localparam int IDXW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [8:0] NENT = 9'(ENTRIES);
  localparam logic [7:0] NB_M1 = 8'(NBEATS - 1);
  localparam logic [3:0] MY_STAGE = 4'(STAGE_ID);

  typedef enum logic [2:0] {IDLE, FWD, KEY, ACT, DROP} state_t;

  logic [KEY_LEN-1:0] key_q  [ENTRIES];
  logic [KEY_LEN-1:0] mask_q [ENTRIES];
  logic [ACT_LEN-1:0] act_q  [ENTRIES];
  logic [ENTRIES-1:0] valid_q;
  logic [ACT_LEN-1:0] dflt_act_q;

  state_t             state_q, state_d;
  logic [7:0]         idx_q, idx_d, cnt_q, cnt_d, inval_idx;
  logic [3:0]         type_q, type_d;
  logic [KEY_LEN-1:0] key_buf_q, key_buf_d, mask_buf_q, mask_buf_d;
  logic [ABUF_W-1:0]  act_buf_q, act_buf_d;
  logic               fwd, key_we, act_we, inval_we, clr_cnt;

  logic [7:0] hdr_idx;
  logic [3:0] hdr_stage, hdr_type;
  assign hdr_idx   = c_s_axis.tdata[7:0];
  assign hdr_stage = c_s_axis.tdata[11:8];
  assign hdr_type  = c_s_axis.tdata[15:12];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      type_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      type_q  <= type_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    key_buf_q  <= key_buf_d;
    mask_buf_q <= mask_buf_d;
    act_buf_q  <= act_buf_d;
  end

  // Commits use the _d buffers so the tlast beat's own payload is included.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    type_d     = type_q;
    cnt_d      = cnt_q;
    key_buf_d  = key_buf_q;
    mask_buf_d = mask_buf_q;
    act_buf_d  = act_buf_q;
    fwd        = 1'b0;
    key_we     = 1'b0;
    act_we     = 1'b0;
    inval_we   = 1'b0;
    clr_cnt    = 1'b0;
    inval_idx  = idx_q;
    if (c_s_axis.tvalid) begin
      unique case (state_q)
        IDLE: begin
          idx_d     = hdr_idx;
          type_d    = hdr_type;
          cnt_d     = '0;
          inval_idx = hdr_idx;
          if (hdr_stage != MY_STAGE) begin
            fwd = 1'b1;
            if (!c_s_axis.tlast) state_d = FWD;
          end else begin
            case (hdr_type)
              4'd0: if (!c_s_axis.tlast) state_d = KEY;
              4'd1: if (!c_s_axis.tlast) state_d = ACT;
              4'd2, 4'd3: begin
                if (c_s_axis.tlast) begin
                  inval_we = (hdr_type == 4'd2) && ({1'b0, hdr_idx} < NENT);
                  clr_cnt  = (hdr_type == 4'd3);
                end else begin
                  state_d = DROP;
                end
              end
              default: if (!c_s_axis.tlast) state_d = DROP;
            endcase
          end
        end
        FWD: begin
          fwd = 1'b1;
          if (c_s_axis.tlast) state_d = IDLE;
        end
        KEY: begin
          if (cnt_q == 8'd0) key_buf_d = c_s_axis.tdata[KEY_LEN-1:0];
          if (cnt_q == 8'd1) mask_buf_d = c_s_axis.tdata[KEY_LEN-1:0];
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          if (c_s_axis.tlast) begin
            key_we  = (cnt_q >= 8'd1) && ({1'b0, idx_q} < NENT);
            state_d = IDLE;
          end
        end
        ACT: begin
          if (cnt_q <= NB_M1) act_buf_d[32'(cnt_q) * W +: W] = c_s_axis.tdata;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          if (c_s_axis.tlast) begin
            act_we  = (cnt_q >= NB_M1) && (({1'b0, idx_q} < NENT) || (idx_q == 8'hFF));
            state_d = IDLE;
          end
        end
        DROP: begin
          if (c_s_axis.tlast) begin
            inval_we = (type_q == 4'd2) && ({1'b0, idx_q} < NENT);
            clr_cnt  = (type_q == 4'd3);
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (key_we) begin
      key_q[idx_q[IDXW-1:0]]  <= key_buf_d;
      mask_q[idx_q[IDXW-1:0]] <= mask_buf_d;
    end
    if (act_we && idx_q != 8'hFF) act_q[idx_q[IDXW-1:0]] <= act_buf_d[ACT_LEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      dflt_act_q <= '0;
    end else begin
      if (key_we) valid_q[idx_q[IDXW-1:0]] <= 1'b1;
      if (inval_we) valid_q[inval_idx[IDXW-1:0]] <= 1'b0;
      if (act_we && idx_q == 8'hFF) dflt_act_q <= act_buf_d[ACT_LEN-1:0];
    end
  end

  logic [C_S_AXIS_DATA_WIDTH-1:0]   m_tdata_q;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]  m_tuser_q;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0] m_tkeep_q;
  logic                             m_tvalid_q, m_tlast_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_tdata_q  <= '0;
      m_tuser_q  <= '0;
      m_tkeep_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
    end else begin
      m_tvalid_q <= fwd;
      m_tlast_q  <= fwd && c_s_axis.tlast;
      if (fwd) begin
        m_tdata_q <= c_s_axis.tdata;
        m_tuser_q <= c_s_axis.tuser;
        m_tkeep_q <= c_s_axis.tkeep;
      end
    end
  end

  assign c_m_axis.tdata  = m_tdata_q;
  assign c_m_axis.tuser  = m_tuser_q;
  assign c_m_axis.tkeep  = m_tkeep_q;
  assign c_m_axis.tvalid = m_tvalid_q;
  assign c_m_axis.tlast  = m_tlast_q;

  logic [ENTRIES-1:0] match, s1_match_q;
  logic [PHV_LEN-1:0] s1_phv_q, s2_phv_q, phv_out_q;
  logic               s1_vld_q, s2_vld_q, s2_hit_q, pe_hit, hit_q, action_valid_q;
  logic [7:0]         pe_idx, s2_idx_q, hit_index_q;
  logic [ACT_LEN-1:0] action_q;
  logic [31:0]        hit_cnt_q, miss_cnt_q;

  always_comb begin
    match = '0;
    for (int i = 0; i < ENTRIES; i++)
      match[i] = valid_q[i] && (((extract_key ^ key_q[i]) & ~mask_q[i] & ~extract_mask) == '0);
  end

  // Scanning downward leaves the lowest matching row as the winner.
  always_comb begin
    pe_hit = 1'b0;
    pe_idx = 8'hFF;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (s1_match_q[i]) begin
        pe_hit = 1'b1;
        pe_idx = 8'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    s1_match_q <= match;
    s1_phv_q   <= phv_in;
    s2_hit_q   <= pe_hit;
    s2_idx_q   <= pe_idx;
    s2_phv_q   <= s1_phv_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q       <= 1'b0;
      s2_vld_q       <= 1'b0;
      action_valid_q <= 1'b0;
      action_q       <= '0;
      hit_q          <= 1'b0;
      hit_index_q    <= '0;
      phv_out_q      <= '0;
      hit_cnt_q      <= '0;
      miss_cnt_q     <= '0;
    end else begin
      s1_vld_q       <= key_valid;
      s2_vld_q       <= s1_vld_q;
      action_valid_q <= s2_vld_q;
      if (s2_vld_q) begin
        action_q    <= s2_hit_q ? act_q[s2_idx_q[IDXW-1:0]] : dflt_act_q;
        hit_q       <= s2_hit_q;
        hit_index_q <= s2_hit_q ? s2_idx_q : 8'hFF;
        phv_out_q   <= s2_phv_q;
      end
      if (clr_cnt) begin
        hit_cnt_q  <= '0;
        miss_cnt_q <= '0;
      end else if (s1_vld_q) begin
        if (pe_hit && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
        if (!pe_hit && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign action       = action_q;
  assign action_valid = action_valid_q;
  assign hit          = hit_q;
  assign hit_index    = hit_index_q;
  assign phv_out      = phv_out_q;
  assign hit_cnt      = hit_cnt_q;
  assign miss_cnt     = miss_cnt_q;
endmodule
